// File: rtl/ocm_pkg.sv
// Shared types for the OCM port controller: FSM state encoding, AMO op codes
// and the byte-lane reversal between core order and OCM storage order.
package ocm_pkg;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StReq     = 3'd1,
    StRead    = 3'd2,
    StCapture = 3'd3,
    StWrite   = 3'd4,
    StDone    = 3'd5
  } ocm_state_e;

  typedef enum logic [3:0] {
    AmoSwap = 4'd0,
    AmoAdd  = 4'd1,
    AmoAnd  = 4'd2,
    AmoOr   = 4'd3,
    AmoXor  = 4'd4,
    AmoMin  = 4'd5,
    AmoMax  = 4'd6,
    AmoMinu = 4'd7,
    AmoMaxu = 4'd8
  } amo_op_e;

  function automatic logic [31:0] bswap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/ocm_port_ctrl_if.sv
// Core-side request/response and OCM-side bus signals of one OCM port.
interface ocm_port_ctrl_if #(
  parameter int unsigned ADDR_BITS = 12
);
  logic                 i_valid;
  logic [3:0]           i_we;
  logic                 i_amo;
  logic [3:0]           i_amo_op;
  logic [ADDR_BITS-1:0] i_addr;
  logic [31:0]          i_wdata;
  logic                 o_stall;
  logic                 o_done;
  logic [31:0]          o_rdata;
  logic                 o_req;
  logic                 o_ocm_done;
  logic                 i_grant;
  logic [ADDR_BITS-1:0] o_ocm_addr;
  logic [31:0]          o_ocm_wdata;
  logic [3:0]           o_ocm_we;
  logic [31:0]          i_ocm_rdata;

  modport slave (
    input  i_valid, i_we, i_amo, i_amo_op, i_addr, i_wdata, i_grant, i_ocm_rdata,
    output o_stall, o_done, o_rdata, o_req, o_ocm_done, o_ocm_addr, o_ocm_wdata, o_ocm_we
  );

  modport master (
    output i_valid, i_we, i_amo, i_amo_op, i_addr, i_wdata, i_grant, i_ocm_rdata,
    input  o_stall, o_done, o_rdata, o_req, o_ocm_done, o_ocm_addr, o_ocm_wdata, o_ocm_we
  );
endinterface

// File: rtl/ocm_amo_alu.sv
// Combinational AMO datapath: new value from old word and operand; unknown
// op codes clear we_o so the write is suppressed.
module ocm_amo_alu
  import ocm_pkg::*;
(
  input  logic [31:0] old_i,
  input  logic [31:0] operand_i,
  input  logic [3:0]  op_i,
  output logic [31:0] new_o,
  output logic        we_o
);

  always_comb begin
    new_o = old_i;
    we_o  = 1'b1;
    case (op_i)
      AmoSwap: new_o = operand_i;
      AmoAdd:  new_o = old_i + operand_i;
      AmoAnd:  new_o = old_i & operand_i;
      AmoOr:   new_o = old_i | operand_i;
      AmoXor:  new_o = old_i ^ operand_i;
      AmoMin:  new_o = ($signed(old_i) < $signed(operand_i)) ? old_i : operand_i;
      AmoMax:  new_o = ($signed(old_i) > $signed(operand_i)) ? old_i : operand_i;
      AmoMinu: new_o = (old_i < operand_i) ? old_i : operand_i;
      AmoMaxu: new_o = (old_i > operand_i) ? old_i : operand_i;
      default: we_o  = 1'b0;
    endcase
  end

endmodule

// File: rtl/ocm_port_ctrl.sv
// OCM port controller: arbitrates for the OCM, performs loads, stores and
// atomic read-modify-writes on behalf of the core, restarting on grant loss.
module ocm_port_ctrl
  import ocm_pkg::*;
#(
  parameter int unsigned ADDR_BITS = 12
) (
  input logic            clk,
  input logic            nrst,
  ocm_port_ctrl_if.slave bus
);

  ocm_state_e           state_q;
  logic [3:0]           we_q;
  logic                 amo_q;
  logic [3:0]           op_q;
  logic [ADDR_BITS-1:0] addr_q;
  logic [31:0]          wdata_q;
  logic [31:0]          rdata_q;
  logic [31:0]          amo_new;
  logic                 amo_we;
  logic                 idle;

  ocm_amo_alu u_amo_alu (
    .old_i     (rdata_q),
    .operand_i (wdata_q),
    .op_i      (op_q),
    .new_o     (amo_new),
    .we_o      (amo_we)
  );

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q <= StIdle;
      we_q    <= '0;
      amo_q   <= 1'b0;
      op_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.i_valid) begin
            we_q    <= bus.i_we;
            amo_q   <= bus.i_amo;
            op_q    <= bus.i_amo_op;
            addr_q  <= bus.i_addr;
            wdata_q <= bus.i_wdata;
            state_q <= StReq;
          end
        end
        StReq: begin
          if (bus.i_grant) state_q <= (amo_q || we_q == 4'h0) ? StRead : StWrite;
        end
        StRead: state_q <= bus.i_grant ? StCapture : StReq;
        StCapture: begin
          if (bus.i_grant) begin
            rdata_q <= bswap32(bus.i_ocm_rdata);
            state_q <= amo_q ? StWrite : StDone;
          end else begin
            state_q <= StReq;
          end
        end
        StWrite: state_q <= bus.i_grant ? StDone : StReq;
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign idle            = (state_q == StIdle);
  assign bus.o_req       = !idle;
  assign bus.o_done      = (state_q == StDone);
  assign bus.o_ocm_done  = (state_q == StDone);
  assign bus.o_stall     = (idle && bus.i_valid) || (!idle && state_q != StDone);
  assign bus.o_rdata     = rdata_q;
  assign bus.o_ocm_addr  = idle ? '0 : addr_q;
  assign bus.o_ocm_wdata = idle ? '0 : (amo_q ? amo_new : wdata_q);

  // Gated by nrst so a reset asserted during WRITE never lets the write land.
  always_comb begin
    bus.o_ocm_we = 4'h0;
    if (nrst && state_q == StWrite && bus.i_grant) begin
      bus.o_ocm_we = amo_q ? {4{amo_we}} : we_q;
    end
  end

endmodule

// File: tb/tb_ocm_port_ctrl.sv
// Self-checking bench for ocm_port_ctrl: directed scenarios plus random
// loads/stores/AMOs against a word-level memory reference model.
module tb_ocm_port_ctrl;

  logic clk = 1'b0;
  logic nrst;
  always #5 clk = ~clk;

  ocm_port_ctrl_if #(.ADDR_BITS(12)) bus ();

  ocm_port_ctrl #(.ADDR_BITS(12)) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  // OCM model: byte-reversed storage, one-cycle read latency.
  logic [31:0] mem [4096];
  int          wr_cnt = 0;

  always @(posedge clk) begin
    bus.i_ocm_rdata <= {mem[bus.o_ocm_addr][7:0], mem[bus.o_ocm_addr][15:8],
                        mem[bus.o_ocm_addr][23:16], mem[bus.o_ocm_addr][31:24]};
    if (bus.o_ocm_we != 4'h0) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.o_ocm_we[b]) mem[bus.o_ocm_addr][b*8 +: 8] <= bus.o_ocm_wdata[b*8 +: 8];
      end
      wr_cnt <= wr_cnt + 1;
    end
  end

  int          check_cnt = 0;
  int          pass_cnt  = 0;
  logic [31:0] ref_mem [4096];
  logic [31:0] exp_rdata = 32'h0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_cnt++;
    assert (obs === exp) begin
      pass_cnt++;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference AMO semantics; returns 0 when the op code performs no write.
  function automatic bit amo_ref(input int op, input logic [31:0] old, input logic [31:0] opd,
                                 output logic [31:0] nv);
    longint so = longint'($signed(old));
    longint sd = longint'($signed(opd));
    nv = old;
    case (op)
      0: nv = opd;
      1: nv = 32'((64'(old) + 64'(opd)) % 64'h1_0000_0000);
      2: nv = old & opd;
      3: nv = old | opd;
      4: nv = old ^ opd;
      5: nv = (so <= sd) ? old : opd;
      6: nv = (so >= sd) ? old : opd;
      7: nv = (old <= opd) ? old : opd;
      8: nv = (old >= opd) ? old : opd;
      default: return 1'b0;
    endcase
    return 1'b1;
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, " o_rdata"}, bus.o_rdata, 32'h0);
    chk({tag, " o_req"}, 32'(bus.o_req), 32'h0);
    chk({tag, " o_done"}, 32'(bus.o_done), 32'h0);
    chk({tag, " o_ocm_done"}, 32'(bus.o_ocm_done), 32'h0);
    chk({tag, " o_stall"}, 32'(bus.o_stall), 32'h0);
    chk({tag, " o_ocm_addr"}, 32'(bus.o_ocm_addr), 32'h0);
    chk({tag, " o_ocm_wdata"}, bus.o_ocm_wdata, 32'h0);
    chk({tag, " o_ocm_we"}, 32'(bus.o_ocm_we), 32'h0);
  endtask

  task automatic wait_done(output int lat, output bit done);
    lat  = 0;
    done = 1'b0;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
      done = bus.o_done;
    end
  endtask

  task automatic drive_req(input logic [3:0] we, input logic amo, input logic [3:0] op,
                           input logic [11:0] addr, input logic [31:0] wdata, input logic grant);
    @(negedge clk);
    bus.i_valid  = 1'b1;
    bus.i_we     = we;
    bus.i_amo    = amo;
    bus.i_amo_op = op;
    bus.i_addr   = addr;
    bus.i_wdata  = wdata;
    bus.i_grant  = grant;
    @(negedge clk);
    // Scramble the request inputs: the latched copy must be used from here on.
    bus.i_valid  = 1'b0;
    bus.i_we     = 4'($urandom);
    bus.i_amo    = 1'($urandom);
    bus.i_amo_op = 4'($urandom);
    bus.i_addr   = 12'($urandom);
    bus.i_wdata  = $urandom;
  endtask

  task automatic run_txn(input string tag, input logic [3:0] we, input logic amo,
                         input logic [3:0] op, input logic [11:0] addr,
                         input logic [31:0] wdata, input int hold_low);
    int          lat, w0, exp_lat, exp_w;
    bit          done, ok;
    logic [31:0] nv;
    w0 = wr_cnt;
    drive_req(we, amo, op, addr, wdata, hold_low == 0);
    chk({tag, " req"}, 32'(bus.o_req), 32'h1);
    for (int i = 0; i < hold_low; i++) begin
      chk({tag, " stall_wait"}, 32'(bus.o_stall), 32'h1);
      chk({tag, " we_wait"}, 32'(bus.o_ocm_we), 32'h0);
      @(negedge clk);
    end
    bus.i_grant = 1'b1;
    wait_done(lat, done);
    if (amo) begin
      ok        = amo_ref(int'(op), ref_mem[addr], wdata, nv);
      exp_lat   = 4;
      exp_w     = ok ? 1 : 0;
      exp_rdata = ref_mem[addr];
      if (ok) ref_mem[addr] = nv;
    end else if (we == 4'h0) begin
      exp_lat   = 3;
      exp_w     = 0;
      exp_rdata = ref_mem[addr];
    end else begin
      exp_lat = 2;
      exp_w   = 1;
      for (int b = 0; b < 4; b++) if (we[b]) ref_mem[addr][b*8 +: 8] = wdata[b*8 +: 8];
    end
    chk({tag, " done"}, 32'(done), 32'h1);
    chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, " ocm_done"}, 32'(bus.o_ocm_done), 32'h1);
    chk({tag, " rdata"}, bus.o_rdata, exp_rdata);
    chk({tag, " writes"}, 32'(wr_cnt - w0), 32'(exp_w));
    chk({tag, " mem"}, mem[addr], ref_mem[addr]);
    @(negedge clk);
    chk({tag, " idle_req"}, 32'(bus.o_req), 32'h0);
    chk({tag, " idle_done"}, 32'(bus.o_done), 32'h0);
  endtask

  initial begin
    int          lat, w0, kind;
    bit          done;
    logic [11:0] a;

    nrst         = 1'b0;
    bus.i_valid  = 1'b0;
    bus.i_we     = 4'h0;
    bus.i_amo    = 1'b0;
    bus.i_amo_op = 4'h0;
    bus.i_addr   = 12'h0;
    bus.i_wdata  = 32'h0;
    bus.i_grant  = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    nrst = 1'b1;

    // Store then load back through the byte-reversed OCM.
    run_txn("t1_store", 4'hF, 1'b0, 4'h0, 12'h010, 32'h11223344, 0);
    run_txn("t1_load", 4'h0, 1'b0, 4'h0, 12'h010, 32'h0, 0);
    chk("t1_load_value", bus.o_rdata, 32'h11223344);

    // AMO ADD wraps modulo 2^32.
    run_txn("t2_pre", 4'hF, 1'b0, 4'h0, 12'h011, 32'hFFFFFFFE, 0);
    run_txn("t2_add", 4'h0, 1'b1, 4'd1, 12'h011, 32'd5, 0);
    chk("t2_old", bus.o_rdata, 32'hFFFFFFFE);
    chk("t2_new", mem[12'h011], 32'h00000003);

    // Signed vs unsigned minimum.
    run_txn("t3_pre_a", 4'hF, 1'b0, 4'h0, 12'h012, 32'h1, 0);
    run_txn("t3_min", 4'h0, 1'b1, 4'd5, 12'h012, 32'h80000000, 0);
    chk("t3_min_val", mem[12'h012], 32'h80000000);
    run_txn("t3_pre_b", 4'hF, 1'b0, 4'h0, 12'h013, 32'h1, 0);
    run_txn("t3_minu", 4'h0, 1'b1, 4'd7, 12'h013, 32'h80000000, 0);
    chk("t3_minu_val", mem[12'h013], 32'h1);

    // Unknown AMO op: old value returned, no write.
    run_txn("amo_bad", 4'h0, 1'b1, 4'd12, 12'h012, 32'h12345678, 1);

    // Grant withheld for 10 cycles.
    run_txn("t4_hold", 4'h5, 1'b0, 4'h0, 12'h010, 32'hAABBCCDD, 10);

    // Grant lost during READ of an AMO: restart, single write.
    run_txn("t5_pre", 4'hF, 1'b0, 4'h0, 12'h020, 32'd100, 0);
    w0 = wr_cnt;
    drive_req(4'h0, 1'b1, 4'd1, 12'h020, 32'd7, 1'b1);
    @(negedge clk);
    bus.i_grant = 1'b0;
    chk("t5_read_we", 32'(bus.o_ocm_we), 32'h0);
    @(negedge clk);
    chk("t5_back_req", 32'(bus.o_req), 32'h1);
    chk("t5_back_stall", 32'(bus.o_stall), 32'h1);
    chk("t5_back_done", 32'(bus.o_done), 32'h0);
    @(negedge clk);
    bus.i_grant = 1'b1;
    wait_done(lat, done);
    ref_mem[12'h020] = 32'd107;
    exp_rdata        = 32'd100;
    chk("t5_done", 32'(done), 32'h1);
    chk("t5_latency", 32'(lat), 32'd4);
    chk("t5_writes", 32'(wr_cnt - w0), 32'h1);
    chk("t5_mem", mem[12'h020], 32'd107);
    chk("t5_rdata", bus.o_rdata, 32'd100);
    @(negedge clk);

    // Reset while in WRITE of an AMO.
    run_txn("t6_pre", 4'hF, 1'b0, 4'h0, 12'h030, 32'd55, 0);
    w0 = wr_cnt;
    drive_req(4'h0, 1'b1, 4'd0, 12'h030, 32'hDEADBEEF, 1'b1);
    repeat (3) @(negedge clk);
    chk("t6_in_write", 32'(bus.o_ocm_we), 32'hF);
    nrst = 1'b0;
    #1;
    chk("t6_we_gated", 32'(bus.o_ocm_we), 32'h0);
    @(negedge clk);
    chk_all_zero("t6_after_reset");
    chk("t6_writes", 32'(wr_cnt - w0), 32'h0);
    chk("t6_mem", mem[12'h030], 32'd55);
    nrst      = 1'b1;
    exp_rdata = 32'h0;
    run_txn("t6_reload", 4'h0, 1'b0, 4'h0, 12'h030, 32'h0, 0);

    // Random traffic over a small, fully initialised address window.
    for (int i = 0; i < 8; i++) run_txn("rnd_init", 4'hF, 1'b0, 4'h0, 12'(64 + i), $urandom, 0);
    for (int i = 0; i < 40; i++) begin
      kind = int'($urandom_range(0, 2));
      a    = 12'(64 + $urandom_range(0, 7));
      if (kind == 0) run_txn("rnd_load", 4'h0, 1'b0, 4'h0, a, $urandom, int'($urandom_range(0, 2)));
      else if (kind == 1)
        run_txn("rnd_store", 4'($urandom_range(1, 15)), 1'b0, 4'h0, a, $urandom,
                int'($urandom_range(0, 2)));
      else
        run_txn("rnd_amo", 4'h0, 1'b1, 4'($urandom_range(0, 10)), a, $urandom,
                int'($urandom_range(0, 2)));
    end

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
